mem_bus_controller: RTL
=======================

# mem_bus_controller

Bus controller between the CPU's W-bus and the 64K memory. It owns the MAR (16-bit address) and MDR (8-bit data) and sequences the memory's single active-low-write control line, `nCE`. It turns a simple req/ready/valid handshake into correctly timed memory read and write cycles. It drives the shared bidirectional data bus only while a write is in progress.

## Interface
- `WAIT_CYCLES`, default 1: read access cycles before the MDR captures memory data. Legal range is ≥1.
- `ROM_TOP`, default 16'h07FF: highest ROM address. Used only when the configuration macro is defined.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `CLR`  in  1  asynchronous, active-high reset.
- `req`  in  1  start an access; sampled only when `ready`=1.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr_in`  in  16  access address; loaded into the MAR on accept.
- `wdata`  in  8  write data; loaded into the MDR on accept.
- `ready`  out  1  controller is idle and will accept `req`.
- `valid`  out  1  one-cycle completion pulse (read data or write acknowledge).
- `rdata`  out  8  MDR contents; meaningful while `valid`=1 after a read.
- `err`  out  1  one-cycle pulse alongside `valid` when a write is refused.
- `mem_addr`  out  16  MAR contents, connected to the memory address input.
- `mem_nCE`  out  1  memory control: 1 = read, 0 = write on the next `CLK` edge.
- `mem_data`  inout  8  memory data bus.

## Operation
States:
- **IDLE**: `ready`=1, `mem_nCE`=1, `mem_data` is Z.
  - `req`=1 → MAR←`addr_in`, MDR←`wdata`, latch `we`, cnt←`WAIT_CYCLES`-1, go to ACCESS.
- **ACCESS, read**: `mem_nCE`=1, bus Z.
  - cnt≠0 → decrement cnt.
  - cnt=0 → MDR←`mem_data`, go to DONE.
- **ACCESS, write**: `mem_nCE`=0, `mem_data` driven with MDR.
  - Stays exactly one cycle. The memory writes on the exiting edge, then go to DONE. `WAIT_CYCLES` is ignored for writes.
- **DONE**: `valid`=1, `ready`=0, bus Z, `mem_nCE`=1.
  - Always returns to IDLE on the next edge.

Rules:
- `req` is ignored outside IDLE. No queuing.
- `mem_data` is driven only when state=ACCESS and the access is a write. Driving the bus while `mem_nCE`=1 is forbidden (bus contention).
- `mem_nCE` is a registered decode of state. It must be glitch-free and never 0 outside a write ACCESS.
- MAR and MDR hold their values after DONE until the next accept.

## Timing
- Reset values while `CLR`=1, applied immediately: state IDLE, MAR=0, MDR=0, `ready`=1, `valid`=0, `err`=0, `mem_nCE`=1, `mem_data` Z.
- CLR during a write ACCESS aborts it: `mem_nCE` returns to 1 before the next edge, so no write occurs. CLR during a read discards the read.
- Counting the accept edge as edge 0:
  - Read: `valid` is high for the cycle after edge `WAIT_CYCLES`. Request-to-data latency is `WAIT_CYCLES`+1 edges. `ready` returns after edge `WAIT_CYCLES`+1.
  - Write: `mem_nCE`=0 between edges 0 and 1. `valid` is high between edges 1 and 2. `ready` returns after edge 2.
- Minimum access period is 3 cycles for a write and `WAIT_CYCLES`+2 cycles for a read.
- `req` held high continuously starts a new access on each cycle where `ready`=1.

## Configuration
- `MEM_ROM_PROTECT_EN` defined:
  - A write with `addr_in` ≤ `ROM_TOP` goes from IDLE directly to DONE, with `valid`=1 and `err`=1. `mem_nCE` stays 1, so the memory is unchanged.
  - Reads are unaffected.
- Not defined: `err` is tied to 0, `ROM_TOP` is unused, and all writes proceed.

## Test plan
- Assert CLR mid-run → all outputs hold their reset values. `mem_data` reads Z. No memory location changes.
- Read 16'h0005 with `WAIT_CYCLES`=1 on freshly initialised memory → `valid` after edge 1, `rdata`=8'h05. `mem_nCE` stays 1 throughout.
- Write 8'h20 to 16'h0803, then read 16'h0803 → `mem_nCE`=0 for exactly one cycle, write `valid` after edge 1, read-back `rdata`=8'h20.
- `WAIT_CYCLES`=3, read 16'h0010 → `valid` after edge 3, `rdata`=8'h10. Pulse `req` during ACCESS → ignored, and MAR stays 16'h0010.
- Assert CLR while a write to 16'h0900 of 8'hAA is in ACCESS, before the edge → a later read of 16'h0900 returns 8'h00 (the initial value 0x900 truncated to 8 bits).
- With `MEM_ROM_PROTECT_EN` defined, write 8'hFF to 16'h0003 → `valid`=`err`=1 one cycle after accept. A read of 16'h0003 returns 8'h03.

Source files
------------

// File: rtl/mem_bus_controller.sv
// mem_bus_controller: sequences MAR/MDR and the single active-low write line
// (mem_nCE) of a 64K memory behind a req/ready/valid handshake.
//
// Parameters:
//   WAIT_CYCLES  read access cycles before MDR captures memory data (>= 1)
//   ROM_TOP      highest ROM address, used only with MEM_ROM_PROTECT_EN
//
// Configuration macro:
//   MEM_ROM_PROTECT_EN  refuse writes at or below ROM_TOP (valid+err, no write)
//
// Ports:
//   CLK, CLR          clock, asynchronous active-high reset
//   req, we           start access / write select, sampled while ready=1
//   addr_in, wdata    access address and write data, loaded on accept
//   ready, valid      idle indicator / one-cycle completion pulse
//   rdata, err        MDR contents / refused-write pulse
//   mem_addr, mem_nCE MAR contents / memory control (0 = write on next edge)
//   mem_data          bidirectional memory data bus
module mem_bus_controller #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [15:0] ROM_TOP     = 16'h07FF
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr_in,
  input  logic [7:0]  wdata,
  output logic        ready,
  output logic        valid,
  output logic [7:0]  rdata,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic        mem_nCE,
  inout  wire  [7:0]  mem_data
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic                we_q, we_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                nce_q, nce_d;
  logic                rom_hit_c;

`ifdef MEM_ROM_PROTECT_EN
  assign rom_hit_c = we && (addr_in <= ROM_TOP);
`else
  logic unused_rom_top;
  assign unused_rom_top = ^ROM_TOP;
  assign rom_hit_c      = 1'b0;
`endif

  // State and datapath registers; reset forces nCE high at once so an
  // in-flight write is aborted before the next edge.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      nce_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      nce_q   <= nce_d;
    end
  end

  // Next-state and next-output decode; outputs are computed one cycle ahead
  // so every port is a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    we_d    = we_q;
    ready_d = 1'b0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    nce_d   = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          mar_d = addr_in;
          mdr_d = wdata;
          we_d  = we;
          cnt_d = CNT_W'(WAIT_CYCLES - 1);
          if (rom_hit_c) begin
            // Refused write skips ACCESS entirely; nCE never drops.
            state_d = S_DONE;
            valid_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_ACCESS;
            nce_d   = ~we;
          end
        end else begin
          ready_d = 1'b1;
        end
      end

      S_ACCESS: begin
        if (we_q) begin
          // Memory commits on this edge; single-cycle write regardless of WAIT_CYCLES.
          state_d = S_DONE;
          valid_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mdr_d   = mem_data;
          state_d = S_DONE;
          valid_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Bus is driven exactly when nCE is low, so it can never contend with a read.
  assign mem_data = nce_q ? {DATA_W{1'bz}} : mdr_q;

  assign ready    = ready_q;
  assign valid    = valid_q;
  assign rdata    = mdr_q;
  assign err      = err_q;
  assign mem_addr = mar_q;
  assign mem_nCE  = nce_q;

endmodule
